// File: rtl/return_addr_stack_if.sv
// Control-side interface of the return-address stack.
// master: control/datapath driving push/pop strobes and reading the RET target.
// slave:  the stack itself.
interface return_addr_stack_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic              clr_err;
  logic [ADDR_W-1:0] top_addr;
  logic [CntW-1:0]   count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push,
    output pop,
    output push_addr,
    output clr_err,
    input  top_addr,
    input  count,
    input  empty,
    input  full,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  push,
    input  pop,
    input  push_addr,
    input  clr_err,
    output top_addr,
    output count,
    output empty,
    output full,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// Hardware return-address stack for CALL/RET.
// Storage is a circular buffer addressed as base pointer + count (mod DEPTH), so the
// oldest entry can be discarded in place when the stack overflows.
// Optional build macro: RAS_WRAP_EN -- when defined, a push while full overwrites the
// oldest entry instead of being dropped.
// DEPTH must be a power of two and at least 2.
module return_addr_stack #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 8
) (
  input logic                clk,
  input logic                rst,
  return_addr_stack_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  // Decoded per-edge operation; exactly one applies each cycle.
  typedef enum logic [2:0] {
    OpHold,
    OpPush,
    OpPop,
    OpReplace,
    OpPushFull,
    OpPopEmpty
  } op_e;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   base_q, base_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  op_e               op;
  logic              is_empty;
  logic              is_full;
  logic [PtrW-1:0]   top_idx;
  logic [PtrW-1:0]   free_idx;
  logic              wr_en;
  logic [PtrW-1:0]   wr_idx;
  logic              ovf_set;
  logic              unf_set;

  // Occupancy and buffer positions derived from registered state only.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CntFull);
    // When full, the low count bits are zero so free_idx lands on the oldest entry.
    free_idx = base_q + count_q[PtrW-1:0];
    top_idx  = free_idx - PtrOne;
  end

  // Decode push/pop against the current occupancy.
  always_comb begin
    op = OpHold;
    if (bus.push && bus.pop && !is_empty) begin
      op = OpReplace;
    end else if (bus.push) begin
      // push+pop on an empty stack falls through here as a plain push
      op = is_full ? OpPushFull : OpPush;
    end else if (bus.pop) begin
      op = is_empty ? OpPopEmpty : OpPop;
    end
  end

  // Next-state for pointer, count, storage write and error events.
  always_comb begin
    base_d  = base_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = free_idx;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      OpPush: begin
        wr_en   = 1'b1;
        wr_idx  = free_idx;
        count_d = count_q + CntOne;
      end
      OpPop: begin
        count_d = count_q - CntOne;
      end
      OpReplace: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      OpPushFull: begin
        ovf_set = 1'b1;
`ifdef RAS_WRAP_EN
        // Overwrite the oldest slot and rotate the base so it becomes the new top.
        wr_en  = 1'b1;
        wr_idx = base_q;
        base_d = base_q + PtrOne;
`endif
      end
      OpPopEmpty: begin
        unf_set = 1'b1;
      end
      default: ;
    endcase
  end

  // Sticky flags: a new error in the same cycle as clr_err wins.
  always_comb begin
    ovf_d = (ovf_q & ~bus.clr_err) | ovf_set;
    unf_d = (unf_q & ~bus.clr_err) | unf_set;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage; not cleared by reset since it is unreadable while empty.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_idx] <= bus.push_addr;
    end
  end

  // Outputs: top entry is a combinational read, occupancy is registered.
  always_comb begin
    bus.top_addr  = is_empty ? '0 : mem_q[top_idx];
    bus.count     = count_q;
    bus.empty     = is_empty;
    bus.full      = is_full;
    bus.overflow  = ovf_q;
    bus.underflow = unf_q;
  end

  // Count must stay within 0..DEPTH and empty/full are exclusive.
  assert property (@(posedge clk) count_q <= CntFull);
  assert property (@(posedge clk) !(is_empty && is_full));

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: directed scenarios plus a randomized run
// against a queue-based reference stack.
module tb_return_addr_stack;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;
`ifdef RAS_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  return_addr_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: stack as a queue, back = top.
  logic [ADDR_W-1:0] model_q[$];
  bit m_ovf;
  bit m_unf;

  function automatic logic [ADDR_W-1:0] exp_top();
    if (model_q.size() == 0) return '0;
    return model_q[model_q.size()-1];
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
    return CW'(model_q.size());
  endfunction

  // Apply one cycle of inputs, advance one edge, update the model, sample at +1.
  task automatic step(input bit p, input bit o, input logic [ADDR_W-1:0] a,
                      input bit c, input bit r);
    bit o_ev;
    bit u_ev;
    bus.push      = p;
    bus.pop       = o;
    bus.push_addr = a;
    bus.clr_err   = c;
    rst           = r;
    @(posedge clk);
    #1;
    o_ev = 1'b0;
    u_ev = 1'b0;
    if (r) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p && o && model_q.size() > 0) begin
        model_q[model_q.size()-1] = a;
      end else if (p) begin
        if (model_q.size() < DEPTH) begin
          model_q.push_back(a);
        end else begin
          o_ev = 1'b1;
          if (Wrap) begin
            void'(model_q.pop_front());
            model_q.push_back(a);
          end
        end
      end else if (o) begin
        if (model_q.size() > 0) void'(model_q.pop_back());
        else u_ev = 1'b1;
      end
      if (c) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      m_ovf = m_ovf | o_ev;
      m_unf = m_unf | u_ev;
    end
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 12'h0a1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h0a2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h000, 1'b0, 1'b0); // sets underflow before reset
    checks++;
    if (bus.underflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_underflow got %b want 1", bus.underflow);
    end
    step(1'b1, 1'b0, 12'h0a3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h0b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 12'h0b2, 1'b0, 1'b1);
    checks++;
    if (bus.count !== CW'(0)) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", bus.count);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL reset_empty_full got %b%b want 10", bus.empty, bus.full);
    end
    checks++;
    if (bus.top_addr !== 12'h000) begin
      errors++;
      $display("FAIL reset_top got %h want 000", bus.top_addr);
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b want 00", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_lifo();
    logic [ADDR_W-1:0] want [3];
    want[0] = 12'h030;
    want[1] = 12'h020;
    want[2] = 12'h010;
    step(1'b1, 1'b0, 12'h010, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h020, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h030, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.top_addr !== want[i]) begin
        errors++;
        $display("FAIL lifo_top[%0d] got %h want %h", i, bus.top_addr, want[i]);
      end
      step(1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    end
    checks++;
    if (bus.top_addr !== 12'h000 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL lifo_final got top=%h empty=%b want top=000 empty=1",
               bus.top_addr, bus.empty);
    end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] want;
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 12'(12'h100 + i), 1'b0, 1'b0);
    checks++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_state got full=%b ovf=%b cnt=%0d want full=1 ovf=1 cnt=%0d",
               bus.full, bus.overflow, bus.count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      want = Wrap ? 12'(12'h108 - i) : 12'(12'h107 - i);
      checks++;
      if (bus.top_addr !== want) begin
        errors++;
        $display("FAIL ovf_pop[%0d] got %h want %h", i, bus.top_addr, want);
      end
      step(1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.top_addr !== 12'h000 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained got empty=%b top=%h ovf=%b want 1 000 1",
               bus.empty, bus.top_addr, bus.overflow);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== CW'(0)) begin
      errors++;
      $display("FAIL unf_set got unf=%b cnt=%0d want unf=1 cnt=0", bus.underflow, bus.count);
    end
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear got %b want 0", bus.underflow);
    end
    // Clear and a new underflow in the same cycle: the new error wins.
    step(1'b0, 1'b1, 12'h000, 1'b1, 1'b0);
    checks++;
    if (bus.underflow !== 1'b1) begin
      errors++;
      $display("FAIL unf_clr_vs_set got %b want 1", bus.underflow);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 12'h011, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h022, 1'b0, 1'b0);
    step(1'b1, 1'b1, 12'h0aa, 1'b0, 1'b0);
    checks++;
    if (bus.count !== CW'(2) || bus.top_addr !== 12'h0aa) begin
      errors++;
      $display("FAIL simul_replace got cnt=%0d top=%h want cnt=2 top=0aa",
               bus.count, bus.top_addr);
    end
    step(1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    checks++;
    if (bus.top_addr !== 12'h011) begin
      errors++;
      $display("FAIL simul_pop got %h want 011", bus.top_addr);
    end
  endtask

  task automatic test_simul_empty();
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    step(1'b1, 1'b1, 12'h055, 1'b0, 1'b0);
    checks++;
    if (bus.count !== CW'(1) || bus.top_addr !== 12'h055 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty got cnt=%0d top=%h unf=%b want cnt=1 top=055 unf=0",
               bus.count, bus.top_addr, bus.underflow);
    end
  endtask

  task automatic test_random();
    bit p;
    bit o;
    bit c;
    bit r;
    int bias;
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      bias = ((i / 60) % 2 == 0) ? 75 : 25; // alternate filling and draining phases
      p = ($urandom_range(0, 99) < bias);
      o = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 199) == 0);
      step(p, o, ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)), c, r);
      checks++;
      if (bus.top_addr !== exp_top() || bus.count !== exp_cnt() ||
          bus.empty !== (model_q.size() == 0) || bus.full !== (model_q.size() == DEPTH) ||
          bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
        errors++;
        $display("FAIL rand[%0d] got top=%h cnt=%0d e=%b f=%b o=%b u=%b want top=%h cnt=%0d e=%b f=%b o=%b u=%b",
                 i, bus.top_addr, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow,
                 exp_top(), exp_cnt(), model_q.size() == 0, model_q.size() == DEPTH,
                 m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_addr = '0;
    bus.clr_err   = 1'b0;
    rst           = 1'b1;
    m_ovf         = 1'b0;
    m_unf         = 1'b0;
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_simul_empty();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
